// File: rtl/divisor_sequencer.sv
// Steps a clock_divider through a programmed {divisor, duration} table,
// holding each divisor for max(duration,1) inclk cycles.
module divisor_sequencer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3,
    parameter int DIV_W = 32,
    parameter int DUR_W = 32
) (
    input  logic             inclk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [DIV_W-1:0] wr_divisor,
    input  logic [DUR_W-1:0] wr_duration,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    output logic [DIV_W-1:0] divisor,
    output logic             div_enable,
    output logic [IDX_W-1:0] step_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t           state_q, state_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] divisor_q, divisor_d;
    logic             div_enable_q, div_enable_d;
    logic [IDX_W-1:0] step_idx_q, step_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] tab_div_q [DEPTH];
    logic [DIV_W-1:0] tab_div_d [DEPTH];
    logic [DUR_W-1:0] tab_dur_q [DEPTH];
    logic [DUR_W-1:0] tab_dur_d [DEPTH];

    logic             do_load, go_done, go_idle;
    logic [IDX_W-1:0] load_idx, nxt;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        divisor_d    = divisor_q;
        div_enable_d = div_enable_q;
        step_idx_d   = step_idx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tab_div_d    = tab_div_q;
        tab_dur_d    = tab_dur_q;
        do_load      = 1'b0;
        go_done      = 1'b0;
        go_idle      = 1'b0;
        load_idx     = '0;
        nxt          = step_idx_q + 1'b1;

        if (wr_en) begin
            tab_div_d[wr_addr] = wr_divisor;
            tab_dur_d[wr_addr] = wr_duration;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (tab_div_q[0] != '0) do_load = 1'b1;
                    else                    go_done = 1'b1;
                end
            end
            PLAY: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (cnt_q > DUR_W'(1)) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (step_idx_q == IDX_W'(DEPTH-1) || tab_div_q[nxt] == '0) begin
                    // end of table: wrap to entry 0 or finish
                    if (loop_en) do_load = 1'b1;
                    else         go_done = 1'b1;
                end else begin
                    do_load  = 1'b1;
                    load_idx = nxt;
                end
            end
            DONE:    go_idle = 1'b1;
            default: go_idle = 1'b1;
        endcase

        // Entry values are sampled from the pre-write table on load.
        if (do_load) begin
            state_d      = PLAY;
            step_idx_d   = load_idx;
            divisor_d    = tab_div_q[load_idx];
            cnt_d        = (tab_dur_q[load_idx] == '0) ? DUR_W'(1) : tab_dur_q[load_idx];
            div_enable_d = 1'b1;
            busy_d       = 1'b1;
        end
        if (go_done || go_idle) begin
            state_d      = go_done ? DONE : IDLE;
            done_d       = go_done;
            divisor_d    = '0;
            div_enable_d = 1'b0;
            step_idx_d   = '0;
            busy_d       = 1'b0;
            cnt_d        = '0;
        end
    end

    always_ff @(posedge inclk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            divisor_q    <= '0;
            div_enable_q <= 1'b0;
            step_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tab_div_q[i] <= '0;
                tab_dur_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            divisor_q    <= divisor_d;
            div_enable_q <= div_enable_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tab_div_q    <= tab_div_d;
            tab_dur_q    <= tab_dur_d;
        end
    end

    assign divisor    = divisor_q;
    assign div_enable = div_enable_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_divisor_sequencer.sv
// Directed bench for divisor_sequencer with hand-computed expected sequences.
module tb_divisor_sequencer;

    logic        inclk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_divisor = '0;
    logic [31:0] wr_duration = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [31:0] divisor;
    logic        div_enable;
    logic [2:0]  step_idx;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    divisor_sequencer dut (
        .inclk(inclk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_divisor(wr_divisor), .wr_duration(wr_duration), .start(start),
        .stop(stop), .loop_en(loop_en), .divisor(divisor), .div_enable(div_enable),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 inclk = ~inclk;

    task automatic tick();
        @(posedge inclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] dv, input logic [31:0] du);
        wr_en = 1'b1; wr_addr = a; wr_divisor = dv; wr_duration = du;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_div"}, divisor, 0);
        chk({tag, "_en"}, {31'b0, div_enable}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_idx"}, {29'b0, step_idx}, 0);
    endtask

    int exp_div2 [8] = '{2, 2, 2, 2, 5, 5, 5, 0};
    int exp_idx2 [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    int exp_div3 [12] = '{2, 2, 2, 2, 5, 5, 5, 2, 2, 2, 2, 9};
    int exp_idx3 [12] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};

    initial begin
        // 1: reset, then start with empty table
        tick(); tick();
        idle_outs("rst");
        chk("rst_done", {31'b0, done}, 0);
        reset = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        chk("empty_done", {31'b0, done}, 1);
        chk("empty_en", {31'b0, div_enable}, 0);
        chk("empty_busy", {31'b0, busy}, 0);
        tick();
        chk("empty_done_end", {31'b0, done}, 0);
        chk("empty_en2", {31'b0, div_enable}, 0);

        // 2: two-entry sequence, no loop
        wr(0, 2, 4); wr(1, 5, 3);
        loop_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("seq_div%0d", i), divisor, exp_div2[i]);
            chk($sformatf("seq_idx%0d", i), {29'b0, step_idx}, exp_idx2[i]);
            chk($sformatf("seq_done%0d", i), {31'b0, done}, (i == 7) ? 1 : 0);
            chk($sformatf("seq_busy%0d", i), {31'b0, busy}, (i == 7) ? 0 : 1);
            chk($sformatf("seq_en%0d", i), {31'b0, div_enable}, (i == 7) ? 0 : 1);
            tick();
        end
        chk("seq_done_clr", {31'b0, done}, 0);
        idle_outs("seq_end");

        // 3 + 6b: looping, rewrite entry 1 while it plays
        loop_en = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("loop_div%0d", i), divisor, exp_div3[i]);
            chk($sformatf("loop_idx%0d", i), {29'b0, step_idx}, exp_idx3[i]);
            chk($sformatf("loop_done%0d", i), {31'b0, done}, 0);
            if (i == 4) begin
                wr_en = 1'b1; wr_addr = 1; wr_divisor = 9; wr_duration = 3;
            end
            tick();
            wr_en = 1'b0;
        end
        stop = 1'b1; tick(); stop = 1'b0;
        idle_outs("loop_stop");
        chk("loop_stop_done", {31'b0, done}, 0);
        loop_en = 1'b0;

        // 4: full table, zero durations
        for (int i = 0; i < 8; i++) wr(3'(i), 32'(10 + i), 0);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_div%0d", i), divisor, 32'(10 + i));
            chk($sformatf("full_idx%0d", i), {29'b0, step_idx}, 32'(i));
            tick();
        end
        chk("full_done", {31'b0, done}, 1);
        idle_outs("full_end");
        tick();
        chk("full_done_clr", {31'b0, done}, 0);

        // 5: stop mid-entry; start+stop together in IDLE
        wr(0, 7, 10);
        start = 1'b1; tick(); start = 1'b0;
        chk("stop_pre_div", divisor, 7);
        tick(); tick();
        stop = 1'b1; tick(); stop = 1'b0;
        idle_outs("stop");
        chk("stop_done", {31'b0, done}, 0);
        tick();
        chk("stop_done2", {31'b0, done}, 0);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        idle_outs("ss");
        chk("ss_done", {31'b0, done}, 0);
        tick();
        chk("ss_busy2", {31'b0, busy}, 0);

        // 6a: reset mid-PLAY clears outputs and table
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("mid_busy", {31'b0, busy}, 1);
        reset = 1'b0; tick(); reset = 1'b1;
        idle_outs("midrst");
        chk("midrst_done", {31'b0, done}, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("midrst_empty_done", {31'b0, done}, 1);
        chk("midrst_empty_en", {31'b0, div_enable}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
